// File: rtl/lif_sched_pkg.sv
// -----------------------------------------------------------------------------
// lif_sched_pkg
// Shared types and helpers for the LIF spike scheduler.
//   sched_state_t : timestep sequencing states
//   idx_w(n)      : index width for n requesters, never less than 1
// -----------------------------------------------------------------------------
package lif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    LEAK = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  function automatic int idx_w(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/lif_spike_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: returns the first set bit of
// i_eligible at or after i_pointer, wrapping modulo NUM_REQ.
// Ports:
//   i_eligible    [NUM_REQ] candidate requesters
//   i_pointer     [IDX_W]   search start index
//   o_grant_valid           any candidate found
//   o_grant_idx   [IDX_W]   chosen index (0 when none)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_eligible,
  input  logic [IDX_W-1:0]   i_pointer,
  output logic               o_grant_valid,
  output logic [IDX_W-1:0]   o_grant_idx
);

  localparam logic [IDX_W:0] NREQ = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down to offset 0 so the nearest hit
  // to the pointer is the one that sticks.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    w_sum         = '0;
    w_idx         = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_pointer} + (IDX_W+1)'(k);
      if (w_sum >= NREQ) w_sum = w_sum - NREQ;
      w_idx = w_sum[IDX_W-1:0];
      if (i_eligible[w_idx]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/lif_spike_scheduler.sv
// -----------------------------------------------------------------------------
// lif_spike_scheduler
// Shares a single LIF neuron input port among NUM_REQ presynaptic sources.
// Each timestep: drain pending spikes round-robin (each source at most once),
// issue one leak-enable cycle, then pulse timestep_done.
//
// Optional build macro: LIF_SCHED_STATS_EN adds grant_count and start_overrun.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester handshake (ready = not pending)
//   req_weight        packed weights, slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   timestep_start    pulse that begins a timestep (ignored while busy)
//   busy              FSM not IDLE
//   timestep_done     one-cycle end-of-timestep pulse
//   nrn_spike_in      spike strobe to neuron
//   nrn_weight        weight accompanying the spike strobe
//   nrn_leak_en       one-cycle leak enable to neuron
//   grant_id          requester index granted this cycle
//   grant_count       (stats) grants in the last completed timestep
//   start_overrun     (stats) sticky: start seen while busy
// -----------------------------------------------------------------------------
module lif_spike_scheduler
  import lif_sched_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 16,
  localparam int IDX_W      = idx_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_weight,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          timestep_start,
  output logic                          busy,
  output logic                          timestep_done,
  output logic                          nrn_spike_in,
  output logic [DATA_WIDTH-1:0]         nrn_weight,
  output logic                          nrn_leak_en,
  output logic [IDX_W-1:0]              grant_id
`ifdef LIF_SCHED_STATS_EN
  ,
  output logic [IDX_W:0]                grant_count,
  output logic                          start_overrun
`endif
);

  sched_state_t          r_state;
  logic [NUM_REQ-1:0]    r_pending;
  logic [NUM_REQ-1:0]    r_served;
  logic [DATA_WIDTH-1:0] r_wt [NUM_REQ];
  logic [IDX_W-1:0]      r_ptr;
  logic                  r_spike;
  logic [DATA_WIDTH-1:0] r_weight;
  logic [IDX_W-1:0]      r_gid;
  logic                  r_leak;
  logic                  r_done;

  logic [NUM_REQ-1:0]    w_accept;
  logic [NUM_REQ-1:0]    w_served_eff;
  logic [NUM_REQ-1:0]    w_eligible;
  logic                  w_gnt_vld;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_start;
  logic                  w_arb_active;
  logic                  w_grant;
  logic [IDX_W-1:0]      w_ptr_nxt;

  assign w_accept  = req_valid & ~r_pending;
  assign req_ready = ~r_pending;
  assign w_start   = (r_state == IDLE) && timestep_start;

  // Arbitration is resolved on the edge that enters (or stays in) ARB, so the
  // registered spike output appears in the same cycle the grant is counted.
  // On the starting edge the served set is about to be cleared, so it is
  // ignored for that first decision.
  assign w_served_eff = (r_state == IDLE) ? '0 : r_served;
  assign w_eligible   = r_pending & ~w_served_eff;
  assign w_arb_active = w_start || (r_state == ARB);
  assign w_grant      = w_arb_active && w_gnt_vld;

  always_comb begin
    w_ptr_nxt = w_gnt_idx + IDX_W'(1);
    if (w_gnt_idx == IDX_W'(NUM_REQ - 1)) w_ptr_nxt = '0;
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_eligible    (w_eligible),
    .i_pointer     (r_ptr),
    .o_grant_valid (w_gnt_vld),
    .o_grant_idx   (w_gnt_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_served  <= '0;
      r_ptr     <= '0;
      r_spike   <= 1'b0;
      r_weight  <= '0;
      r_gid     <= '0;
      r_leak    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) r_wt[i] <= '0;
    end else begin
      r_spike  <= 1'b0;
      r_weight <= '0;
      r_gid    <= '0;
      r_leak   <= 1'b0;
      r_done   <= 1'b0;

      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept[i]) begin
          r_pending[i] <= 1'b1;
          r_wt[i]      <= req_weight[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      case (r_state)
        IDLE: begin
          if (timestep_start) begin
            r_served <= '0;
            if (w_gnt_vld) begin
              r_state <= ARB;
            end else begin
              r_state <= LEAK;
              r_leak  <= 1'b1;
            end
          end
        end
        ARB: begin
          if (!w_gnt_vld) begin
            r_state <= LEAK;
            r_leak  <= 1'b1;
          end
        end
        LEAK: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      // Grant side effects; placed after the served clear so the new bit wins.
      // The granted index is pending, hence not ready, so no accept collides.
      if (w_grant) begin
        r_spike              <= 1'b1;
        r_weight             <= r_wt[w_gnt_idx];
        r_gid                <= w_gnt_idx;
        r_pending[w_gnt_idx] <= 1'b0;
        r_served[w_gnt_idx]  <= 1'b1;
        r_ptr                <= w_ptr_nxt;
      end
    end
  end

  assign busy          = (r_state != IDLE);
  assign nrn_spike_in  = r_spike;
  assign nrn_weight    = r_weight;
  assign grant_id      = r_gid;
  assign nrn_leak_en   = r_leak;
  assign timestep_done = r_done;

`ifdef LIF_SCHED_STATS_EN
  logic [IDX_W:0] r_cnt;
  logic [IDX_W:0] r_gcount;
  logic           r_overrun;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_gcount  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_start)      r_cnt <= w_grant ? (IDX_W+1)'(1) : '0;
      else if (w_grant) r_cnt <= r_cnt + (IDX_W+1)'(1);
      if (r_state == DONE) r_gcount <= r_cnt;
      if (timestep_start && (r_state != IDLE)) r_overrun <= 1'b1;
    end
  end

  assign grant_count   = r_gcount;
  assign start_overrun = r_overrun;
`else
  // Statistics outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_lif_spike_scheduler.sv
module tb_lif_spike_scheduler;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int K_SPK  = 0;
  localparam int K_LEAK = 1;
  localparam int K_DONE = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_weight;
  logic [NR-1:0]      req_ready;
  logic               timestep_start;
  logic               busy;
  logic               timestep_done;
  logic               nrn_spike_in;
  logic [DW-1:0]      nrn_weight;
  logic               nrn_leak_en;
  logic [IW-1:0]      grant_id;
`ifdef LIF_SCHED_STATS_EN
  logic [IW:0]        grant_count;
  logic               start_overrun;
`endif

  lif_spike_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_weight     (req_weight),
    .req_ready      (req_ready),
    .timestep_start (timestep_start),
    .busy           (busy),
    .timestep_done  (timestep_done),
    .nrn_spike_in   (nrn_spike_in),
    .nrn_weight     (nrn_weight),
    .nrn_leak_en    (nrn_leak_en),
    .grant_id       (grant_id)
`ifdef LIF_SCHED_STATS_EN
    ,
    .grant_count    (grant_count),
    .start_overrun  (start_overrun)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int id;
    int wt;
    int c;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int id, input int wt, input int c);
    exp_t e;
    e.kind = kind; e.id = id; e.wt = wt; e.c = c;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input int w);
    req_valid[i] = 1'b1;
    req_weight[i*DW +: DW] = DW'(w);
  endtask

  task automatic pulse_start();
    timestep_start = 1'b1;
    tick();
    timestep_start = 1'b0;
  endtask

  // Monitor: pops one expectation per output event and checks kind, cycle,
  // and for spikes the granted index and weight.
  exp_t e;
  int   akind;
  bit   excl;
  bit   ok;
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_event kind=%0d got=none need_cyc=%0d", sb[0].kind, sb[0].c);
        void'(sb.pop_front());
      end
      if (nrn_spike_in || nrn_leak_en || timestep_done) begin
        total++;
        akind = nrn_spike_in ? K_SPK : (nrn_leak_en ? K_LEAK : K_DONE);
        excl  = (int'(nrn_spike_in) + int'(nrn_leak_en) + int'(timestep_done)) == 1;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event got kind=%0d cyc=%0d need=none", akind, cyc);
        end else begin
          e  = sb.pop_front();
          ok = excl && (e.kind == akind) && (e.c == cyc) &&
               ((akind != K_SPK) || ((int'(grant_id) == e.id) && (int'(nrn_weight) == e.wt)));
          if (!ok) begin
            bad++;
            $display("FAIL event got kind=%0d cyc=%0d id=%0d wt=%0d excl=%0d need kind=%0d cyc=%0d id=%0d wt=%0d",
                     akind, cyc, grant_id, nrn_weight, excl, e.kind, e.c, e.id, e.wt);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1, "watchdog");
  end

  int t;

  initial begin
    rst_n          = 1'b0;
    req_valid      = '0;
    req_weight     = '0;
    timestep_start = 1'b0;
    tick(2);

    chk("rst_spike", int'(nrn_spike_in), 0);
    chk("rst_leak",  int'(nrn_leak_en), 0);
    chk("rst_done",  int'(timestep_done), 0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_ready", int'(req_ready), 15);
`ifdef LIF_SCHED_STATS_EN
    chk("rst_gcount",  int'(grant_count), 0);
    chk("rst_overrun", int'(start_overrun), 0);
`endif
    rst_n = 1'b1;
    tick();

    // Round-robin timestep 1: requesters 0,2,3
    set_req(0, 10); set_req(2, 20); set_req(3, 30);
    tick();
    req_valid = '0;
    chk("pend_ready", int'(req_ready), 4'b0010);
    t = cyc;
    push(K_SPK, 0, 10, t + 1);
    push(K_SPK, 2, 20, t + 2);
    push(K_SPK, 3, 30, t + 3);
    push(K_LEAK, 0, 0, t + 4);
    push(K_DONE, 0, 0, t + 5);
    pulse_start();
    tick(7);

    // Round-robin timestep 2: requesters 1,3; extra start while busy ignored
    set_req(1, 11); set_req(3, 33);
    tick();
    req_valid = '0;
    t = cyc;
    push(K_SPK, 1, 11, t + 1);
    push(K_SPK, 3, 33, t + 2);
    push(K_LEAK, 0, 0, t + 3);
    push(K_DONE, 0, 0, t + 4);
    pulse_start();
    chk("busy_in_arb", int'(busy), 1);
    pulse_start();
    tick(6);
    chk("idle_after_ts2", int'(busy), 0);
`ifdef LIF_SCHED_STATS_EN
    chk("overrun_set", int'(start_overrun), 1);
`endif

    // Once per timestep: req0 held valid
    set_req(0, 5);
    tick();
    t = cyc;
    push(K_SPK, 0, 5, t + 1);
    push(K_LEAK, 0, 0, t + 2);
    push(K_DONE, 0, 0, t + 3);
    pulse_start();
    tick(5);
    t = cyc;
    push(K_SPK, 0, 5, t + 1);
    push(K_LEAK, 0, 0, t + 2);
    push(K_DONE, 0, 0, t + 3);
    pulse_start();
    tick(5);
    req_valid = '0;
    chk("reaccept_pending", int'(req_ready), 4'b1110);

    // Late arrival: req2 joins during ARB (pointer now 1, req0 still pending)
    set_req(1, 3);
    tick();
    req_valid = '0;
    t = cyc;
    push(K_SPK, 1, 3, t + 1);
    push(K_SPK, 0, 5, t + 2);
    push(K_SPK, 2, 7, t + 3);
    push(K_LEAK, 0, 0, t + 4);
    push(K_DONE, 0, 0, t + 5);
    pulse_start();
    set_req(2, 7);
    tick();
    req_valid = '0;
    tick(6);

    // Reset mid-ARB with 3 pending (pointer 3 -> first grant is 0)
    set_req(0, 1); set_req(1, 2); set_req(2, 3);
    tick();
    req_valid = '0;
    t = cyc;
    push(K_SPK, 0, 1, t + 1);
    pulse_start();
    tick();
    chk("midarb_spike", int'(nrn_spike_in), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_spike",  int'(nrn_spike_in), 0);
    chk("arst_weight", int'(nrn_weight), 0);
    chk("arst_gid",    int'(grant_id), 0);
    chk("arst_leak",   int'(nrn_leak_en), 0);
    chk("arst_done",   int'(timestep_done), 0);
    chk("arst_busy",   int'(busy), 0);
    chk("arst_ready",  int'(req_ready), 15);
`ifdef LIF_SCHED_STATS_EN
    chk("arst_overrun", int'(start_overrun), 0);
    chk("arst_gcount",  int'(grant_count), 0);
`endif
    tick(2);
    rst_n = 1'b1;
    tick();
    t = cyc;
    push(K_LEAK, 0, 0, t + 1);
    push(K_DONE, 0, 0, t + 2);
    pulse_start();
    tick(4);
    chk("post_rst_ready", int'(req_ready), 15);

`ifdef LIF_SCHED_STATS_EN
    // All four pending, pointer 0; start pulsed during ARB
    set_req(0, 1); set_req(1, 2); set_req(2, 3); set_req(3, 4);
    tick();
    req_valid = '0;
    t = cyc;
    push(K_SPK, 0, 1, t + 1);
    push(K_SPK, 1, 2, t + 2);
    push(K_SPK, 2, 3, t + 3);
    push(K_SPK, 3, 4, t + 4);
    push(K_LEAK, 0, 0, t + 5);
    push(K_DONE, 0, 0, t + 6);
    pulse_start();
    pulse_start();
    tick(6);
    chk("gcount_4",      int'(grant_count), 4);
    chk("overrun_arb",   int'(start_overrun), 1);
    tick(3);
    chk("overrun_stick", int'(start_overrun), 1);
    rst_n = 1'b0;
    #1;
    chk("overrun_clr", int'(start_overrun), 0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    tick(2);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_spike_scheduler.md
Name: lif_spike_scheduler

Overview:
- Shares one LIF neuron's single input port (spike_in/weight) among NUM_REQ presynaptic spike sources.
- Sequences each simulation timestep in order: drain pending spikes round-robin, then issue one leak-enable cycle, then signal completion.
- Sits between the axon/synapse front end and the LIF neuron datapath.

Parameters:
NUM_REQ, 4, number of presynaptic requesters (2..16)
DATA_WIDTH, 16, weight width; matches neuron DATA_WIDTH
IDX_W, $clog2(NUM_REQ), requester index width (derived, not overridden)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester spike request
req_weight  input  NUM_REQ*DATA_WIDTH  per-requester weight; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  NUM_REQ  per-requester accept
timestep_start  input  1  pulse; begins a timestep
busy  output  1  high whenever FSM is not IDLE
timestep_done  output  1  one-cycle pulse at end of timestep
nrn_spike_in  output  1  to neuron spike_in
nrn_weight  output  DATA_WIDTH  to neuron weight
nrn_leak_en  output  1  to neuron leak enable
grant_id  output  IDX_W  index of the requester granted this cycle

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; pending, served and stored weights cleared; rr pointer=0; all outputs 0.
- Acceptance, any state:
  - req_ready[i] = ~pending[i].
  - On valid&ready, next cycle: pending[i]=1 and wt[i]=req_weight slice.
- FSM states: IDLE, ARB, LEAK, DONE.
  - IDLE: timestep_start=1 -> ARB; served cleared.
  - ARB: eligible = pending & ~served.
    - If eligible != 0: grant the first eligible index at or after the rr pointer, wrapping modulo NUM_REQ.
    - Grant outputs, registered and valid the same cycle as the grant decision: nrn_spike_in=1, nrn_weight=wt[g], grant_id=g.
    - Grant side effects: pending[g] cleared, served[g] set, pointer=(g+1) mod NUM_REQ.
    - If eligible == 0: -> LEAK; nrn_spike_in=0.
  - LEAK: nrn_leak_en=1 for exactly one cycle -> DONE.
  - DONE: timestep_done=1 for one cycle -> IDLE.
- Fairness and termination:
  - Each requester is granted at most once per timestep.
  - A requester re-accepted after its grant stays pending into the next timestep.
  - ARB therefore lasts at most NUM_REQ cycles.
- Pointer updates only on a grant; it is held across timesteps.
- Latency: timestep_start at cycle T with k eligible -> grants T+1..T+k, leak at T+k+1, done at T+k+2. With k=0: leak T+1, done T+2.
- Simultaneous events:
  - Accept and grant of the same index cannot collide, because ready=0 while pending.
  - An accept into a non-served index during ARB becomes eligible from the next cycle within the same timestep.
  - An accept into a served index is deferred to the next timestep.
- timestep_start while busy: ignored, no queuing.
- Outputs nrn_spike_in, nrn_leak_en and timestep_done are mutually exclusive.
- Reset mid-timestep: everything returns immediately to reset values; pending spikes are lost.

Optional Feature:
- Macro: LIF_SCHED_STATS_EN.
- When defined, adds output grant_count [IDX_W:0]:
  - holds the number of grants issued in the most recent completed timestep;
  - updated in DONE;
  - reset value 0.
- Also adds sticky output start_overrun, set when timestep_start arrives while busy. It is cleared only by reset.
- When not defined, neither port nor its logic exists.

Decomposition:
- Package lif_sched_pkg holds:
  - state enum sched_state_t {IDLE, ARB, LEAK, DONE};
  - function idx_w(n) returning $clog2(n), minimum 1.
- Sub-module rr_arbiter, purely combinational:
  - inputs: eligible vector and pointer;
  - outputs: grant_valid and grant_idx;
  - instantiated once.

Test Plan:
1. Reset: rst_n=0 mid-ARB with 3 pending -> all outputs 0 and req_ready=4'b1111 with no clock edge. Release, then timestep_start -> leak at T+1, done at T+2.
2. Round-robin:
   - Timestep 1: requests 0,2,3 (weights 10,20,30), pointer 0, start -> grants in order 0,2,3 with weights 10,20,30, then leak, then done.
   - Timestep 2: req1 and req3 pending -> grant order 1,3 (pointer was 0 after grant 3).
3. Once per timestep: req0 held valid continuously with weight 5 -> exactly one nrn_spike_in per timestep, re-accepted after grant. Second timestep grants it again.
4. Late arrival: during ARB, req2 (not yet served) asserts with weight 7 -> granted in the same timestep before LEAK.
5. timestep_start pulsed while busy -> ignored, timestep_done pulses once.
6. Optional feature (LIF_SCHED_STATS_EN):
   - 4 requesters all pending -> grant_count=4 after DONE;
   - start during ARB -> start_overrun=1, which stays set until reset.
